// File: rtl/decoder_rr_arbiter_if.sv
// rtl/decoder_rr_arbiter_if.sv - request/grant bus between requesters and the shared 2-to-4 decoder arbiter
interface decoder_rr_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic       addr0;
    logic       addr1;
    logic       enable;
    logic [3:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  addr0, addr1, enable, grant, busy, timeout
    );

    modport slave (
        input  req, done,
        output addr0, addr1, enable, grant, busy, timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter driving a shared 2-to-4 decoder; ARB_TIMEOUT_EN adds forced release
module decoder_rr_arbiter #(
    parameter int TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 reset_n,
    decoder_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       rel_norm;
    logic       rel_force;

    if (TIMEOUT < 1) begin : g_bad_timeout
    end

    assign idx      = {bus.addr1, bus.addr0};
    assign rel_norm = bus.done || !bus.req[idx];

    // Scan starts one past the last grantee, so the previous winner is considered last.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && bus.req[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    assign rel_force = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            bus.timeout <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            if (state != GRANT) begin
                cnt <= '0;
            end else if (!rel_norm && rel_force) begin
                bus.timeout <= 1'b1;
            end else if (!rel_norm) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign rel_force   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 2'd3;
            bus.addr0  <= 1'b0;
            bus.addr1  <= 1'b0;
            bus.enable <= 1'b0;
            bus.grant  <= 4'b0000;
            bus.busy   <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (found) begin
                        state      <= GRANT;
                        bus.addr0  <= win[0];
                        bus.addr1  <= win[1];
                        bus.enable <= 1'b1;
                        bus.grant  <= 4'b0001 << win;
                        bus.busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // Address bits keep their value; the decoder is gated off by enable.
                    if (rel_norm || rel_force) begin
                        state      <= GAP;
                        ptr        <= idx;
                        bus.enable <= 1'b0;
                        bus.grant  <= 4'b0000;
                        bus.busy   <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.enable <= 1'b0;
                    bus.grant  <= 4'b0000;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
